// File: rtl/ws2801_pkg.sv
// WS2801 strip driver: shared types and constants.
// Holds the pixel struct, FSM state enum and the serial word width.
package ws2801_pkg;

    // Bits shifted out per LED (8 red, 8 green, 8 blue).
    localparam int WS2801_BITS = 24;

    typedef struct packed {
        logic [7:0] red;
        logic [7:0] green;
        logic [7:0] blue;
    } rgb_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_LOAD,
        ST_SHIFT,
        ST_LATCH
    } ws2801_state_t;

    // Wire order on the strip: red[7] first, blue[0] last.
    function automatic logic [WS2801_BITS-1:0] rgb_pack(
        input rgb_t px
    );
        return {px.red, px.green, px.blue};
    endfunction

endpackage

// File: rtl/ws2801_bit_serializer.sv
// WS2801 bit serializer: shift register, bit counter and cko divider.
// Ports:
//   i_clk, i_reset         - clock, synchronous active-high reset
//   i_load                 - capture i_word, restart at bit 23
//   i_shift                - advance the bit timing this cycle
//   i_word                 - 24-bit word to send, MSB first
//   o_sdo, o_cko           - registered serial data / clock
//   o_last_bit_done        - high in the final cycle of bit 0
module ws2801_bit_serializer
    import ws2801_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic                   i_load,
    input  logic                   i_shift,
    input  logic [WS2801_BITS-1:0] i_word,
    output logic                   o_sdo,
    output logic                   o_cko,
    output logic                   o_last_bit_done
);

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BW = $clog2(WS2801_BITS);

    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [BW-1:0] BIT_TOP  = BW'(WS2801_BITS - 1);

    logic [WS2801_BITS-1:0] r_shreg;
    logic [BW-1:0]          r_bitcnt;
    logic [DW-1:0]          r_div;
    logic                   r_cko;

    logic w_half_end;

    // Last cycle of either the low or the high half of a bit.
    assign w_half_end = i_shift && (r_div == DIV_LAST);

    assign o_last_bit_done = w_half_end && r_cko &&
                             (r_bitcnt == '0);

    // The shift register MSB is the data pin. After 24 shifts it
    // holds only zeros, so sdo idles low between LEDs and frames.
    assign o_sdo = r_shreg[WS2801_BITS-1];
    assign o_cko = r_cko;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_shreg  <= '0;
            r_bitcnt <= '0;
            r_div    <= '0;
            r_cko    <= 1'b0;
        end else if (i_load) begin
            r_shreg  <= i_word;
            r_bitcnt <= BIT_TOP;
            r_div    <= '0;
            r_cko    <= 1'b0;
        end else if (i_shift) begin
            if (w_half_end) begin
                r_div <= '0;
                r_cko <= ~r_cko;
                // Falling cko and the next data bit change together,
                // giving a full low half of setup before the rise.
                if (r_cko) begin
                    r_shreg <= {r_shreg[WS2801_BITS-2:0], 1'b0};
                    if (r_bitcnt != '0) begin
                        r_bitcnt <= r_bitcnt - BW'(1);
                    end
                end
            end else begin
                r_div <= r_div + DW'(1);
            end
        end
    end

endmodule

// File: rtl/ws2801_strip_driver.sv
// WS2801 strip driver: fetches one RGB word per LED from a frame
// buffer, serializes it on sdo/cko, then holds cko low to latch.
// Ports:
//   i_clk, i_reset  - clock, synchronous active-high reset
//   i_start         - level request to send one frame
//   o_busy          - state is not IDLE
//   o_done          - one-cycle pulse after a frame's latch gap
//   o_rd_en         - frame-buffer read strobe
//   o_rd_addr       - LED index (0 = nearest the controller)
//   i_rd_data       - RGB word, valid the cycle after o_rd_en
//   o_sdo, o_cko    - serial data / clock to the first LED
// Build option: define WS2801_AUTO_REFRESH_EN to loop frames
// continuously after one start until reset.
module ws2801_strip_driver
    import ws2801_pkg::*;
#(
    parameter int LEDS         = 50,
    parameter int CLK_DIV      = 4,
    parameter int LATCH_CYCLES = 30000,
    localparam int AW = (LEDS > 1) ? $clog2(LEDS) : 1
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_start,
    output logic          o_busy,
    output logic          o_done,
    output logic          o_rd_en,
    output logic [AW-1:0] o_rd_addr,
    input  logic [23:0]   i_rd_data,
    output logic          o_sdo,
    output logic          o_cko
);

    localparam int LW = $clog2(LATCH_CYCLES + 1);

    localparam logic [AW-1:0] IDX_LAST = AW'(LEDS - 1);
    localparam logic [LW-1:0] LAT_LAST = LW'(LATCH_CYCLES - 1);

    ws2801_state_t r_state;
    logic [AW-1:0] r_idx;
    logic [LW-1:0] r_lat;
    logic          r_rd_en;
    logic [AW-1:0] r_rd_addr;
    logic          r_done;
    // Set by a start request; a reset-entered latch has it clear,
    // which suppresses done (and auto refresh) for that gap.
    logic          r_armed;

    rgb_t          w_pixel;
    logic          w_load;
    logic          w_shift;
    logic          w_last_bit;

    assign w_pixel = i_rd_data;
    assign w_load  = (r_state == ST_LOAD);
    assign w_shift = (r_state == ST_SHIFT);

    assign o_busy    = (r_state != ST_IDLE);
    assign o_done    = r_done;
    assign o_rd_en   = r_rd_en;
    assign o_rd_addr = r_rd_addr;

    ws2801_bit_serializer #(
        .CLK_DIV (CLK_DIV)
    ) u_ser (
        .i_clk           (i_clk),
        .i_reset         (i_reset),
        .i_load          (w_load),
        .i_shift         (w_shift),
        .i_word          (rgb_pack(w_pixel)),
        .o_sdo           (o_sdo),
        .o_cko           (o_cko),
        .o_last_bit_done (w_last_bit)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state   <= ST_LATCH;
            r_idx     <= '0;
            r_lat     <= '0;
            r_rd_en   <= 1'b0;
            r_rd_addr <= '0;
            r_done    <= 1'b0;
            r_armed   <= 1'b0;
        end else begin
            r_rd_en <= 1'b0;
            r_done  <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_state   <= ST_FETCH;
                        r_idx     <= '0;
                        r_rd_en   <= 1'b1;
                        r_rd_addr <= '0;
                        r_armed   <= 1'b1;
                    end
                end
                ST_FETCH: begin
                    r_state <= ST_LOAD;
                end
                ST_LOAD: begin
                    r_state <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    if (w_last_bit) begin
                        if (r_idx == IDX_LAST) begin
                            r_state <= ST_LATCH;
                            r_lat   <= '0;
                        end else begin
                            r_state   <= ST_FETCH;
                            r_idx     <= r_idx + AW'(1);
                            r_rd_en   <= 1'b1;
                            r_rd_addr <= r_idx + AW'(1);
                        end
                    end
                end
                ST_LATCH: begin
                    if (r_lat == LAT_LAST) begin
                        r_lat  <= '0;
                        r_done <= r_armed;
`ifdef WS2801_AUTO_REFRESH_EN
                        if (r_armed) begin
                            r_state   <= ST_FETCH;
                            r_idx     <= '0;
                            r_rd_en   <= 1'b1;
                            r_rd_addr <= '0;
                        end else begin
                            r_state <= ST_IDLE;
                        end
`else
                        r_state <= ST_IDLE;
                        r_armed <= 1'b0;
`endif
                    end else begin
                        r_lat <= r_lat + LW'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ws2801_strip_driver.sv
// Bench for ws2801_strip_driver: model RAM, 3-LED WS2801 chain model,
// expected pixels queued at frame launch and popped at each latch.
module tb_ws2801_strip_driver;

    localparam int LEDS         = 3;
    localparam int CLK_DIV      = 2;
    localparam int LATCH_CYCLES = 100;
    localparam int PER_LED      = 2 + 48 * CLK_DIV;
    localparam int FRAME        = LEDS * PER_LED + LATCH_CYCLES;
    localparam int GAP_LATCH    = 40;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        busy;
    logic        done;
    logic        rd_en;
    logic [1:0]  rd_addr;
    logic [23:0] rd_data;
    logic        sdo;
    logic        cko;

    logic [23:0] ram [LEDS];
    logic [23:0] exp_q [$];

    int n_cmp = 0;
    int n_bad = 0;

    // Chain model and monitor state, owned by the main process.
    int          cyc      = 0;
    int          done_cnt = 0;
    int          rd_cnt   = 0;
    int          rises    = 0;
    int          bitcnt   = 0;
    int          stab     = 0;
    int          low      = 0;
    logic        p_cko    = 1'b0;
    logic        p_sdo    = 1'b0;
    logic        first_bit = 1'b0;
    logic [23:0] sh [LEDS];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rd_en) rd_data <= ram[rd_addr];
    end

    ws2801_strip_driver #(
        .LEDS         (LEDS),
        .CLK_DIV      (CLK_DIV),
        .LATCH_CYCLES (LATCH_CYCLES)
    ) dut (
        .i_clk     (clk),
        .i_reset   (reset),
        .i_start   (start),
        .o_busy    (busy),
        .o_done    (done),
        .o_rd_en   (rd_en),
        .o_rd_addr (rd_addr),
        .i_rd_data (rd_data),
        .o_sdo     (sdo),
        .o_cko     (cko)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One cycle: sample at negedge, run the chain model.
    task automatic tick();
        logic [23:0] e;
        @(negedge clk);
        cyc++;
        if (done) done_cnt++;
        if (rd_en) rd_cnt++;
        if (sdo !== p_sdo) check("sdo_edge_cko_low", 32'(cko), 32'd0);
        if (sdo === p_sdo) stab++; else stab = 1;
        if (cko && !p_cko) begin
            rises++;
            check("sdo_setup", 32'(stab > CLK_DIV), 32'd1);
            if (bitcnt == 0) first_bit = sdo;
            if (bitcnt < 24 * LEDS)
                sh[bitcnt / 24] = {sh[bitcnt / 24][22:0], sdo};
            bitcnt++;
        end
        if (cko) low = 0; else low++;
        if (low == GAP_LATCH && bitcnt > 0) begin
            if (bitcnt == 24 * LEDS) begin
                check("exp_avail", 32'(exp_q.size() >= LEDS), 32'd1);
                if (exp_q.size() >= LEDS) begin
                    for (int i = 0; i < LEDS; i++) begin
                        e = exp_q.pop_front();
                        check($sformatf("led%0d", i), {8'h0, sh[i]},
                              {8'h0, e});
                    end
                end
            end
            bitcnt = 0;
        end
        p_cko = cko;
        p_sdo = sdo;
    endtask

    task automatic wait_done(input int bound, output int at);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (!done && n < bound);
        at = done ? cyc : -1;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 1000) begin
            n++;
            tick();
        end
    endtask

    task automatic set_ram(input logic [23:0] a, input logic [23:0] b,
                           input logic [23:0] c, input bit push);
        ram[0] = a;
        ram[1] = b;
        ram[2] = c;
        if (push) begin
            exp_q.push_back(a);
            exp_q.push_back(b);
            exp_q.push_back(c);
        end
    endtask

    task automatic run_frame(input string tag, input logic [23:0] a,
                             input logic [23:0] b, input logic [23:0] c);
        int r0, rd0, c0, at;
        set_ram(a, b, c, 1'b1);
        r0  = rises;
        rd0 = rd_cnt;
        start = 1'b1;
        tick();
        start = 1'b0;
        check({tag, "_rd_en_latency"}, 32'(rd_en), 32'd1);
        check({tag, "_rd_addr0"}, 32'(rd_addr), 32'd0);
        c0 = cyc;
        wait_done(2 * FRAME, at);
        check({tag, "_done_cycle"}, 32'(at - c0), 32'(FRAME));
        check({tag, "_cko_rises"}, 32'(rises - r0), 32'd72);
        check({tag, "_first_bit"}, 32'(first_bit), 32'(a[23]));
        check({tag, "_reads"}, 32'(rd_cnt - rd0), 32'(LEDS));
        check({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int n, at, c0, c1, r0, d0, rd1;
        reset = 1'b1;
        start = 1'b0;
        for (int i = 0; i < LEDS; i++) sh[i] = '0;
        set_ram(24'h0, 24'h0, 24'h0, 1'b0);

        // Reset values and post-reset latch gap.
        tick();
        tick();
        check("rst_sdo", 32'(sdo), 32'd0);
        check("rst_cko", 32'(cko), 32'd0);
        check("rst_rd_en", 32'(rd_en), 32'd0);
        check("rst_rd_addr", 32'(rd_addr), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_busy", 32'(busy), 32'd1);
        reset = 1'b0;
        r0 = rises;
        wait_idle(n);
        check("t1_busy_cycles", 32'(n), 32'(LATCH_CYCLES));
        check("t1_no_done", 32'(done_cnt), 32'd0);
        check("t1_cko_low", 32'(rises - r0), 32'd0);
        repeat (5) tick();

`ifndef WS2801_AUTO_REFRESH_EN
        // Single frame, edge count and setup checks.
        run_frame("t2", 24'hFFFFFF, 24'hF0F0F0, 24'hAAAAAA);

        // Start held high: one frame, then restart right after IDLE.
        set_ram(24'h123456, 24'h789ABC, 24'hDEF012, 1'b1);
        exp_q.push_back(24'h123456);
        exp_q.push_back(24'h789ABC);
        exp_q.push_back(24'hDEF012);
        r0 = rises;
        start = 1'b1;
        tick();
        check("t4_rd_en", 32'(rd_en), 32'd1);
        c0  = cyc;
        rd1 = rd_cnt;
        wait_done(2 * FRAME, at);
        check("t4_done1_cycle", 32'(at - c0), 32'(FRAME));
        check("t4_idle_at_done", 32'(busy), 32'd0);
        check("t4_one_frame_reads", 32'(rd_cnt - rd1), 32'd2);
        tick();
        check("t4_restart", 32'(rd_en), 32'd1);
        start = 1'b0;
        c1 = cyc;
        wait_done(2 * FRAME, at);
        check("t4_done2_cycle", 32'(at - c1), 32'(FRAME));
        rd1 = rd_cnt;
        repeat (20) tick();
        check("t4_no_third", 32'(rd_cnt - rd1), 32'd0);
        check("t4_rises", 32'(rises - r0), 32'd144);

        // Reset in the middle of LED1.
        set_ram(24'hABCDEF, 24'h13579B, 24'h2468AC, 1'b0);
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (!(rd_en && rd_addr == 2'd1) && n < 500) begin
            tick();
            n++;
        end
        check("t5_led1_fetch", 32'(rd_en && rd_addr == 2'd1), 32'd1);
        repeat (30) tick();
        reset = 1'b1;
        d0 = done_cnt;
        tick();
        reset = 1'b0;
        check("t5_rst_sdo", 32'(sdo), 32'd0);
        check("t5_rst_cko", 32'(cko), 32'd0);
        check("t5_rst_busy", 32'(busy), 32'd1);
        r0 = rises;
        wait_idle(n);
        check("t5_gap_cycles", 32'(n), 32'(LATCH_CYCLES));
        check("t5_gap_cko_low", 32'(rises - r0), 32'd0);
        check("t5_no_done", 32'(done_cnt - d0), 32'd0);
        run_frame("t5", 24'h000000, 24'h555555, 24'hFFF000);
`else
        // Auto refresh: one start, frames repeat with fresh RAM.
        set_ram(24'hFFFFFF, 24'hF0F0F0, 24'hAAAAAA, 1'b1);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("t6_rd_en", 32'(rd_en), 32'd1);
        c0 = cyc;
        for (int k = 0; k < 3; k++) begin
            wait_done(2 * FRAME, at);
            check($sformatf("t6_done%0d_cycle", k), 32'(at - c0),
                  32'(FRAME));
            check($sformatf("t6_busy%0d", k), 32'(busy), 32'd1);
            c0 = at;
            if (k < 2) begin
                set_ram(24'($urandom), 24'($urandom), 24'($urandom),
                        1'b1);
            end
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        d0 = done_cnt;
        wait_idle(n);
        check("t6_stop_gap", 32'(n), 32'(LATCH_CYCLES));
        check("t6_stop_no_done", 32'(done_cnt - d0), 32'd0);
        repeat (5) tick();
        check("t6_stopped", 32'(busy), 32'd0);
`endif

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
